// File: rtl/bram_sweep_controller_if.sv
// ---------------------------------------------------------------------------
// bram_sweep_controller_if
//   Groups the control/status and BRAM-write signals of the sweep controller.
//
//   master : register-bank side. Drives start, trig, count_max, n_sweeps and
//            observes addr_sclr, address, wen, sweep_index, busy, done.
//   slave  : the sweep controller itself (mirror image of master).
//
//   Parameters
//     COUNT_WIDTH : word counter width; byte address is COUNT_WIDTH+2 bits.
//     SWEEP_WIDTH : width of sweep count and sweep index.
// ---------------------------------------------------------------------------
interface bram_sweep_controller_if #(
  parameter int COUNT_WIDTH = 5,
  parameter int SWEEP_WIDTH = 8
);
  logic                   start;
  logic                   trig;
  logic [COUNT_WIDTH-1:0] count_max;
  logic [SWEEP_WIDTH-1:0] n_sweeps;

  logic                   addr_sclr;
  logic [COUNT_WIDTH+1:0] address;
  logic                   wen;
  logic [SWEEP_WIDTH-1:0] sweep_index;
  logic                   busy;
  logic                   done;

  modport master (
    output start, trig, count_max, n_sweeps,
    input  addr_sclr, address, wen, sweep_index, busy, done
  );

  modport slave (
    input  start, trig, count_max, n_sweeps,
    output addr_sclr, address, wen, sweep_index, busy, done
  );
endinterface

// File: rtl/bram_sweep_controller.sv
// ---------------------------------------------------------------------------
// bram_sweep_controller
//   Arms an acquisition on start, then for each of n_sweeps sweeps: pulses
//   addr_sclr, waits for the trigger, and writes count_max+1 words with
//   wen=1 and byte address {count, 2'b00}. Pulses done once at the end.
//
//   Ports
//     clk  : single clock, rising edge.
//     sclr : synchronous active-high reset (priority over everything).
//     bus  : bram_sweep_controller_if.slave (start, trig, count_max,
//            n_sweeps in; addr_sclr, address, wen, sweep_index, busy, done out).
//
//   Build option
//     BRAM_SWEEP_CONTROLLER_TRIGGER_EN : when defined, every sweep waits in
//     WAIT_TRIG for trig=1. When undefined, trig is ignored and WAIT_TRIG
//     lasts one cycle, giving back-to-back sweeps with a 2-cycle gap.
// ---------------------------------------------------------------------------
module bram_sweep_controller #(
  parameter int COUNT_WIDTH = 5,
  parameter int SWEEP_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    sclr,
  bram_sweep_controller_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT_TRIG,
    S_RUN,
    S_FINISH
  } state_t;

  state_t                 state;
  state_t                 next_state;
  logic [COUNT_WIDTH-1:0] count;
  logic [COUNT_WIDTH-1:0] count_max_q;
  logic [SWEEP_WIDTH-1:0] n_sweeps_q;
  logic [SWEEP_WIDTH-1:0] sweep_index;
  logic                   last_word;
  logic                   last_sweep;
  logic                   trig_ok;

  assign last_word  = (count == count_max_q);
  // n_sweeps_q is never 0 once latched, so the subtraction cannot underflow.
  assign last_sweep = (sweep_index == SWEEP_WIDTH'(n_sweeps_q - 1'b1));

`ifdef BRAM_SWEEP_CONTROLLER_TRIGGER_EN
  assign trig_ok = bus.trig;
`else
  // Free-running: the trigger input is read but has no effect.
  assign trig_ok = bus.trig | 1'b1;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (sclr) state <= S_IDLE;
    else      state <= next_state;
  end

  // NOTE: next_state gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:      if (bus.start) next_state = S_ARM;
      S_ARM:       next_state = S_WAIT_TRIG;
      S_WAIT_TRIG: if (trig_ok) next_state = S_RUN;
      S_RUN: begin
        if (last_word) next_state = last_sweep ? S_FINISH : S_ARM;
      end
      S_FINISH:    next_state = S_IDLE;
      default:     next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      count       <= '0;
      count_max_q <= '0;
      n_sweeps_q  <= '0;
      sweep_index <= '0;
    end else begin
      if (state == S_IDLE && bus.start) begin
        count_max_q <= bus.count_max;
        n_sweeps_q  <= (bus.n_sweeps == '0) ? SWEEP_WIDTH'(1) : bus.n_sweeps;
        sweep_index <= '0;
      end
      if (state == S_ARM) count <= '0;
      if (state == S_RUN) begin
        // Count stops at count_max so a full-range sweep never wraps.
        if (!last_word)       count       <= count + 1'b1;
        else if (!last_sweep) sweep_index <= sweep_index + 1'b1;
      end
    end
  end

  assign bus.addr_sclr   = (state == S_ARM);
  assign bus.wen         = (state == S_RUN);
  assign bus.busy        = (state != S_IDLE);
  assign bus.done        = (state == S_FINISH);
  assign bus.address     = {count, 2'b00};
  assign bus.sweep_index = sweep_index;

endmodule

// File: tb/tb_bram_sweep_controller.sv
module tb_bram_sweep_controller;
  localparam int CW   = 5;
  localparam int SW   = 8;
  localparam int AW   = CW + 2;
  localparam int MAXC = 4096;
`ifdef BRAM_SWEEP_CONTROLLER_TRIGGER_EN
  localparam bit TRIG_EN = 1'b1;
`else
  localparam bit TRIG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic sclr;
  always #5 clk = ~clk;

  bram_sweep_controller_if #(.COUNT_WIDTH(CW), .SWEEP_WIDTH(SW)) bus ();

  bram_sweep_controller #(.COUNT_WIDTH(CW), .SWEEP_WIDTH(SW)) dut (
    .clk  (clk),
    .sclr (sclr),
    .bus  (bus)
  );

  // Expected observable outputs for one cycle.
  typedef struct {
    logic          addr_sclr;
    logic          wen;
    logic          busy;
    logic          done;
    logic [SW-1:0] sweep_index;
    logic [AW-1:0] address;
  } obs_t;

  // One acquisition: configuration, trigger pattern, and whether to jitter
  // start/config inputs while busy (must be ignored).
  typedef struct {
    int cmax;
    int nsw;
    int trig_mode;
    bit noise;
  } vec_t;

  int   n_checks = 0;
  int   n_bad    = 0;
  obs_t exp_q[$];
  bit   trig_arr[MAXC];

  task automatic check(input string name, input int cyc,
                       input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", name, cyc, got, expv);
    end
  endtask

  function automatic obs_t mk(bit a, bit w, bit b, bit d, int s, int addr);
    obs_t o;
    o.addr_sclr   = a;
    o.wen         = w;
    o.busy        = b;
    o.done        = d;
    o.sweep_index = SW'(s);
    o.address     = AW'(addr);
    return o;
  endfunction

  // trig value driven during observed cycle i (sampled at the following edge).
  function automatic void fill_trig(int mode);
    for (int i = 0; i < MAXC; i++) begin
      case (mode)
        0:       trig_arr[i] = 1'b1;
        1:       trig_arr[i] = ($urandom_range(0, 2) == 0);
        2:       trig_arr[i] = (i >= 5);
        default: trig_arr[i] = 1'b0;
      endcase
    end
  endfunction

  // Behavioural reference: lists what each cycle after the accepted start
  // should look like, sweep by sweep, word by word.
  function automatic void build_model(int cmax, int nsw);
    int neff = (nsw == 0) ? 1 : nsw;
    int j    = 0;
    bit go;
    exp_q.delete();
    for (int s = 0; s < neff; s++) begin
      exp_q.push_back(mk(1, 0, 1, 0, s, 0)); j++;          // arm
      do begin                                             // wait for trigger
        exp_q.push_back(mk(0, 0, 1, 0, s, 0));
        go = TRIG_EN ? trig_arr[j] : 1'b1;
        j++;
      end while (!go && j < MAXC - 64);
      for (int w = 0; w <= cmax; w++) begin                // burst
        exp_q.push_back(mk(0, 1, 1, 0, s, 4 * w)); j++;
      end
    end
    exp_q.push_back(mk(0, 0, 1, 1, neff - 1, 0));          // done pulse
    exp_q.push_back(mk(0, 0, 0, 0, neff - 1, 0));          // idle again
    exp_q.push_back(mk(0, 0, 0, 0, neff - 1, 0));
  endfunction

  task automatic compare(input string tag, input int j, input obs_t e);
    logic [11:0] got_s, exp_s;
    got_s = {bus.addr_sclr, bus.wen, bus.busy, bus.done, bus.sweep_index};
    exp_s = {e.addr_sclr, e.wen, e.busy, e.done, e.sweep_index};
    check({tag, "_ctl"}, j, 32'(got_s), 32'(exp_s));
    if (e.wen) check({tag, "_addr"}, j, 32'(bus.address), 32'(e.address));
  endtask

  task automatic run_acq(input vec_t v, input string tag);
    int fin;
    fill_trig(v.trig_mode);
    build_model(v.cmax, v.nsw);
    fin = exp_q.size() - 2;
    @(negedge clk);
    bus.count_max = CW'(v.cmax);
    bus.n_sweeps  = SW'(v.nsw);
    bus.trig      = 1'b0;
    bus.start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int j = 0; j < exp_q.size(); j++) begin
      compare(tag, j, exp_q[j]);
      bus.trig = trig_arr[j];
      if (j < fin && v.noise) begin
        bus.start     = 1'($urandom_range(0, 1));
        bus.count_max = CW'($urandom);
        bus.n_sweeps  = SW'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag, input int cyc);
    check({tag, "_ctl"}, cyc,
          32'({bus.addr_sclr, bus.wen, bus.busy, bus.done, bus.sweep_index}), 32'd0);
    check({tag, "_addr"}, cyc, 32'(bus.address), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[7];
    vec_t v;
    bit   found;

    bus.start     = 1'b0;
    bus.trig      = 1'b0;
    bus.count_max = '0;
    bus.n_sweeps  = '0;
    sclr          = 1'b1;

    // Reset held three cycles, then idle without start.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      check_all_zero("reset", i);
    end
    sclr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      check_all_zero("idle_no_start", i);
    end

    tbl[0] = '{7,   1,   2, 1'b0};                 // single sweep, late trigger
    tbl[1] = '{3,   3,   0, 1'b0};                 // multi-sweep, trig held high
    tbl[2] = '{0,   0,   0, 1'b0};                 // one word, n_sweeps 0 -> 1
    tbl[3] = '{31,  1,   1, 1'b0};                 // full range, no wrap
    tbl[4] = '{1,   2,   TRIG_EN ? 0 : 3, 1'b1};   // trig low when ignored, start noise
    tbl[5] = '{0,   255, 0, 1'b0};                 // maximum sweep count
    tbl[6] = '{5,   2,   1, 1'b1};                 // random trig, config jitter
    for (int i = 0; i < 7; i++) run_acq(tbl[i], $sformatf("vec%0d", i));

    // Reset in the middle of a burst, at word 3.
    @(negedge clk);
    bus.count_max = CW'(10);
    bus.n_sweeps  = SW'(1);
    bus.trig      = 1'b1;
    bus.start     = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (bus.wen && bus.address == AW'(12)) found = 1'b1;
      else begin @(posedge clk); @(negedge clk); end
    end
    check("sclr_reach_word3", 0, 32'(found), 32'd1);
    sclr = 1'b1;
    @(posedge clk); @(negedge clk);
    sclr = 1'b0;
    check_all_zero("sclr_mid_run", 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      check("sclr_no_done", i, 32'({bus.done, bus.busy, bus.wen}), 32'd0);
    end
    run_acq('{10, 1, 0, 1'b0}, "after_sclr");

    // Randomised acquisitions against the reference.
    for (int i = 0; i < 6; i++) begin
      v.cmax      = $urandom_range(0, 31);
      v.nsw       = $urandom_range(0, 4);
      v.trig_mode = $urandom_range(0, 2);
      v.noise     = 1'b1;
      run_acq(v, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
